// File: rtl/add_pkg.sv
// Shared widths and types for the adder responder channel.
`timescale 1ns/1ps
package add_pkg;
  localparam int DATA_W = 8;
  localparam int SUM_W  = DATA_W + 1;

  typedef logic [DATA_W-1:0] op_t;
  typedef logic [SUM_W-1:0]  sum_t;
endpackage

// File: rtl/add_rsp_fifo.sv
// First-word-fall-through FIFO. Head data reads as zero while empty.
`timescale 1ns/1ps
module add_rsp_fifo
  import add_pkg::*;
#(
  parameter int WIDTH = add_pkg::SUM_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  // Occupancy and pointer bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign empty    = (cnt == '0);
  assign full     = (cnt == DEPTH[AW:0]);
  assign count    = cnt;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: rtl/add_pipe_rsp.sv
// Adder responder: registered sum stage feeding an output FIFO, with
// valid/ready on both sides and pop statistics.
`timescale 1ns/1ps
module add_pipe_rsp
  import add_pkg::*;
#(
  parameter int DATA_W = add_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ina,
  input  logic [DATA_W-1:0] inb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [CNT_W-1:0]  carry_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            vld_p1;
  logic [DATA_W:0] sum_p1;
  logic            accept;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occ;

  // Space is reserved for the in-flight stage-1 entry, so stage 1 never stalls.
  assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1};
  assign in_ready = rst_n && (occ < DEPTH[CW:0]);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Stage 0 -> 1: valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  // Stage 0 -> 1: full-width sum
  always_ff @(posedge clk) begin
    if (accept) sum_p1 <= {1'b0, ina} + {1'b0, inb};
  end

  // Stage 1 -> FIFO
  add_rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p1),
    .push_data (sum_p1),
    .pop       (pop),
    .pop_data  (out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;

  // FIFO pop -> statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt   <= '0;
      carry_cnt <= '0;
    end else if (pop) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
      if (out[DATA_W]) carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

  a_push_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(vld_p1 && fifo_full));
  a_stall_stable:  assert property (@(posedge clk) disable iff (!rst_n)
                     (out_valid && !out_ready) |=> (out_valid && $stable(out)));
endmodule

// File: tb/tb_add_pipe_rsp.sv
// Scoreboard bench for add_pipe_rsp: directed sends push expected sums,
// a negedge monitor pops and compares whenever the DUT hands out a sum.
`timescale 1ns/1ps
module tb_add_pipe_rsp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  ina;
  logic [7:0]  inb;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [8:0]  out;
  logic [15:0] txn_cnt, carry_cnt;

  logic        w_in_ready, w_out_valid;
  logic [8:0]  w_out;
  logic [3:0]  w_txn_cnt, w_carry_cnt;

  logic [8:0]  exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          last_acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_pipe_rsp #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .txn_cnt(txn_cnt), .carry_cnt(carry_cnt)
  );

  add_pipe_rsp #(.DATA_W(8), .DEPTH(4), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .ina(ina), .inb(inb), .out_valid(w_out_valid), .out_ready(out_ready),
    .out(w_out), .txn_cnt(w_txn_cnt), .carry_cnt(w_carry_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Offer one pair; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
    int guard;
    guard = 0;
    ina = a; inb = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        @(posedge clk); #1;
        last_acc_cyc = cyc;
        break;
      end
      guard++;
      if (guard > 200) begin
        n_total++;
        $display("FAIL send_timeout: pair %0h+%0h not accepted in 200 cycles", a, b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake pops one expected sum.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got %0h with no sum outstanding", out);
      end else begin
        check("sum", 32'(out), 32'(exp_q.pop_front()));
        check("twin_out", {22'b0, w_out_valid, w_out}, {22'b0, out_valid, out});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_cyc;
    int rc;
    logic [7:0] ra, rb;
    logic [8:0] rs;

    rst_n = 1'b0; in_valid = 1'b0; ina = '0; inb = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out",       32'(out),       32'd0);
    check("rst_txn",       32'(txn_cnt),   32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Single pair, latency
    out_ready = 1'b1;
    send(8'h12, 8'h34, 9'h046);
    check("lat_edge1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_out_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_out",       32'(out),       32'h046);
    @(posedge clk); #1;
    check("single_txn",   32'(txn_cnt),   32'd1);
    check("single_carry", 32'(carry_cnt), 32'd0);

    // Carry cases
    send(8'hFF, 8'hFF, 9'h1FE);
    drain();
    check("carry1_cnt", 32'(carry_cnt), 32'd1);
    send(8'h80, 8'h80, 9'h100);
    drain();
    check("carry2_cnt", 32'(carry_cnt), 32'd2);
    check("carry2_txn", 32'(txn_cnt),   32'd3);

    // Backpressure
    out_ready = 1'b0;
    send(8'd1, 8'd1, 9'h002);
    send(8'd2, 8'd2, 9'h004);
    send(8'd3, 8'd3, 9'h006);
    send(8'd4, 8'd4, 9'h008);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_stall_valid",  32'(out_valid), 32'd1);
      check("bp_stall_out",    32'(out),       32'h002);
      check("bp_stall_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_reassert", 32'(in_ready), 32'd1);
    drain();
    check("bp_txn", 32'(txn_cnt), 32'd7);

    // Full throughput, random pairs
    rc = 0;
    first_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      rs = {1'b0, ra} + {1'b0, rb};
      if (rs[8]) rc++;
      send(ra, rb, rs);
      if (i == 0) first_cyc = last_acc_cyc;
    end
    check("tput_cycles", 32'(last_acc_cyc - first_cyc), 32'd99);
    drain();
    check("tput_txn",   32'(txn_cnt),   32'd107);
    check("tput_carry", 32'(carry_cnt), 32'(2 + rc));

    // Reset mid-stream: three queued plus one in stage 1
    out_ready = 1'b0;
    send(8'd5, 8'd5, 9'h00A);
    send(8'd6, 8'd6, 9'h00C);
    send(8'd7, 8'd7, 9'h00E);
    send(8'd8, 8'd8, 9'h010);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    check("mid_rst_out",       32'(out),       32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_txn",      32'(txn_cnt),   32'd0);
    check("post_rst_carry",    32'(carry_cnt), 32'd0);
    check("post_rst_in_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_stale", 32'(out_valid), 32'd0);

    // Counter wrap on the 4-bit twin
    for (int i = 1; i <= 17; i++) send(8'(i), 8'(i), 9'(2 * i));
    drain();
    check("wrap_txn_wide",   32'(txn_cnt),     32'd17);
    check("wrap_txn_narrow", 32'(w_txn_cnt),   32'd1);
    check("wrap_carry_narrow", 32'(w_carry_cnt), 32'd0);
    check("wrap_twin_ready", 32'(w_in_ready),  32'(in_ready));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
